// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : Shared constants, header offsets and state encoding for the
//               GMII command receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam logic [7:0]  ETH_PRE     = 8'h55;
    localparam logic [7:0]  ETH_SFD     = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;

    // Byte offsets counted from the first destination-MAC byte
    localparam logic [10:0] OFS_DST_END   = 11'd6;
    localparam logic [10:0] OFS_TYPE      = 11'd12;
    localparam logic [10:0] OFS_TYPE_LO   = 11'd13;
    localparam logic [10:0] OFS_CMD       = 11'd14;
    localparam logic [10:0] OFS_PARAM     = 11'd15;
    localparam logic [10:0] OFS_PARAM_END = 11'd18;
    localparam logic [10:0] HDR_BYTES     = 11'd19;
    localparam logic [10:0] CNT_SAT       = 11'h7FF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        HDR  = 3'd2,
        PAY  = 3'd3,
        DROP = 3'd4
    } state_t;

    // Byte idx (0 = first on the wire, i.e. MSB) of a 48-bit MAC address
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [2:0]  w_rev;
        logic [47:0] w_sh;
        w_rev = 3'd5 - idx;
        w_sh  = mac >> {w_rev, 3'b000};
        return w_sh[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_crc32_d8.sv
`default_nettype none
// ============================================================================
// Module      : eth_crc32_d8
// Description : Combinational reflected CRC-32 update for one byte, LSB of
//               the data byte processed first. Shared with the TX FCS path.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    // Eight serial LFSR steps unrolled into one combinational stage
    always_comb begin
        logic [31:0] w_acc;
        w_acc = i_crc;
        for (int i = 0; i < 8; i++) begin
            w_acc = (w_acc >> 1) ^ (CRC_POLY & {32{w_acc[0] ^ i_data[i]}});
        end
        o_crc = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/eth_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : eth_cmd_rx
// Description : GMII receive command parser. Strips preamble/SFD, filters
//               on destination MAC and EtherType, extracts cmd + 32-bit
//               param and strobes them out only for frames with good FCS.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_cmd_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_02_03,
    parameter logic [15:0] ETH_TYPE  = 16'h88B5,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_eth_rxdv,
    input  logic        i_eth_rxer,
    input  logic [7:0]  i_eth_rxd,
    output logic        o_cmd_come,
    output logic [7:0]  o_cmd,
    output logic [31:0] o_param,
    output logic        o_crc_err,
    output logic        o_frm_drop
);

    localparam logic [10:0] c_MIN_LEN = 11'(MIN_LEN);
    localparam logic [10:0] c_MAX_LEN = 11'(MAX_LEN);

    state_t      r_state;
    logic [10:0] r_cnt;
    logic [31:0] r_crc;
    logic        r_uc_miss;     // dst differs from LOCAL_MAC
    logic        r_bc_miss;     // dst differs from broadcast
    logic        r_type_miss;
    logic        r_err_pend;    // DROP entered through rxer: report at frame end
    logic [7:0]  r_sh_cmd;
    logic [31:0] r_sh_param;

    logic [31:0] w_crc_next;
    logic [10:0] w_cnt_inc;
    logic        w_in_dst;
    logic        w_uc_miss;
    logic        w_bc_miss;
    logic        w_type_miss;
    logic        w_reject;
    logic        w_len_bad;

    eth_crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_data (i_eth_rxd),
        .o_crc  (w_crc_next)
    );

    // Per-byte header checks against the byte currently on the bus
    always_comb begin
        w_cnt_inc   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 11'd1;
        w_in_dst    = (r_cnt < OFS_DST_END);
        w_uc_miss   = w_in_dst && (i_eth_rxd != mac_byte(LOCAL_MAC, r_cnt[2:0]));
        w_bc_miss   = w_in_dst && (i_eth_rxd != 8'hFF);
        w_type_miss = ((r_cnt == OFS_TYPE)    && (i_eth_rxd != ETH_TYPE[15:8])) ||
                      ((r_cnt == OFS_TYPE_LO) && (i_eth_rxd != ETH_TYPE[7:0]));
        w_reject    = (r_uc_miss && r_bc_miss) || r_type_miss;
        w_len_bad   = (r_cnt < HDR_BYTES) || (r_cnt < c_MIN_LEN) || (r_cnt > c_MAX_LEN);
    end

    // Receive FSM with registered strobes and command outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_crc       <= CRC_INIT;
            r_uc_miss   <= 1'b0;
            r_bc_miss   <= 1'b0;
            r_type_miss <= 1'b0;
            r_err_pend  <= 1'b0;
            r_sh_cmd    <= '0;
            r_sh_param  <= '0;
            o_cmd_come  <= 1'b0;
            o_cmd       <= '0;
            o_param     <= '0;
            o_crc_err   <= 1'b0;
            o_frm_drop  <= 1'b0;
        end else begin
            o_cmd_come <= 1'b0;
            o_crc_err  <= 1'b0;
            o_frm_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_err_pend <= 1'b0;
                    if (i_eth_rxdv) begin
                        r_state <= (i_eth_rxd == ETH_PRE) ? PRE : DROP;
                    end
                end
                PRE: begin
                    if (!i_eth_rxdv) begin
                        o_frm_drop <= 1'b1;
                        r_state    <= IDLE;
                    end else if (i_eth_rxer) begin
                        r_err_pend <= 1'b1;
                        r_state    <= DROP;
                    end else if (i_eth_rxd == ETH_SFD) begin
                        r_cnt       <= '0;
                        r_crc       <= CRC_INIT;
                        r_uc_miss   <= 1'b0;
                        r_bc_miss   <= 1'b0;
                        r_type_miss <= 1'b0;
                        r_state     <= HDR;
                    end else if (i_eth_rxd != ETH_PRE) begin
                        r_state <= DROP;
                    end
                end
                HDR, PAY: begin
                    if (!i_eth_rxdv) begin
                        // Evaluation edge: exactly one verdict per frame
                        if (w_reject || w_len_bad) begin
                            o_frm_drop <= 1'b1;
                        end else if (r_crc != CRC_RESIDUE) begin
                            o_crc_err <= 1'b1;
                        end else begin
                            o_cmd_come <= 1'b1;
                            o_cmd      <= r_sh_cmd;
                            o_param    <= r_sh_param;
                        end
                        r_state <= IDLE;
                    end else if (i_eth_rxer) begin
                        r_err_pend <= 1'b1;
                        r_state    <= DROP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        r_crc <= w_crc_next;
                        if (w_uc_miss)   r_uc_miss   <= 1'b1;
                        if (w_bc_miss)   r_bc_miss   <= 1'b1;
                        if (w_type_miss) r_type_miss <= 1'b1;
                        if (r_cnt == OFS_TYPE_LO) r_state <= PAY;
                        if (r_cnt == OFS_CMD) r_sh_cmd <= i_eth_rxd;
                        if ((r_cnt >= OFS_PARAM) && (r_cnt <= OFS_PARAM_END)) begin
                            r_sh_param <= {r_sh_param[23:0], i_eth_rxd};
                        end
                    end
                end
                DROP: begin
                    if (!i_eth_rxdv) begin
                        o_frm_drop <= r_err_pend;
                        r_err_pend <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
